// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cfg_chain_pkg.sv
// Shared types and constants for the serial configuration chain controller.
package gf180mcu_fd_sc_mcu9t5v0__cfg_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cfg_chain_bitcnt.sv
// Bit counter for the chain shift: clear, increment and terminal count at WIDTH-1.
module gf180mcu_fd_sc_mcu9t5v0__cfg_chain_bitcnt #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] k,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      k <= '0;
    end else if (inc) begin
      k <= k + 1'b1;
    end
  end

  assign tc = (k == CW'(WIDTH - 1));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cfg_chain_ctrl.sv
// Loads a parallel word LSB-first into a cascaded dffq chain and reads the
// previous chain contents back from the tail in the same pass.
module gf180mcu_fd_sc_mcu9t5v0__cfg_chain_ctrl
  import gf180mcu_fd_sc_mcu9t5v0__cfg_chain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SDO,
  output logic             SCE,
  input  logic             SDI,
  output logic [WIDTH-1:0] DOUT,
  output logic             DONE,
  output logic             BUSY
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, rb;
  logic [CW-1:0]    k;
  logic             tc, accept, last_bit, cnt_clr, cnt_inc;

  gf180mcu_fd_sc_mcu9t5v0__cfg_chain_bitcnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bitcnt (
    .clk (CLK),
    .rst (RST),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .k   (k),
    .tc  (tc)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (DIN_VALID) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (tc) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter wraps back to zero on the last shift so it never reaches WIDTH.
  assign last_bit = (state == SHIFT) && tc;
  assign cnt_clr  = accept || last_bit;
  assign cnt_inc  = (state == SHIFT) && !tc;

  // SDO/SCE are flopped from next-state values so the clock gate sees clean edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      sr    <= '0;
      rb    <= '0;
      SDO   <= 1'b0;
      SCE   <= 1'b0;
      DOUT  <= '0;
    end else begin
      state <= state_nxt;
      SCE   <= (state_nxt == SHIFT);
      if (accept) begin
        sr  <= DIN;
        SDO <= DIN[0];
      end else if (state == SHIFT) begin
        sr  <= sr >> 1;
        SDO <= tc ? 1'b0 : sr[1];
      end else begin
        SDO <= 1'b0;
      end
      if (state == SHIFT) begin
        rb <= {SDI, rb[WIDTH-1:1]};
      end
      if (last_bit) begin
        DOUT <= {SDI, rb[WIDTH-1:1]};
      end
    end
  end

  assign DIN_READY = (state == IDLE);
  assign BUSY      = (state == SHIFT);
  assign DONE      = (state == FIN);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__cfg_chain_ctrl.sv
// Scoreboard bench: a 16-bit controller driving a behavioural chain, plus a 2-bit corner instance.
module tb_gf180mcu_fd_sc_mcu9t5v0__cfg_chain_ctrl;

  localparam int W  = 16;
  localparam int W2 = 2;

  typedef struct packed {
    logic         known;
    logic [W-1:0] word;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, din_valid, din_ready, sdo, sce, sdi, done, busy;
  logic [W-1:0] din, dout, chain;

  logic          rst2, valid2, ready2, sdo2, sce2, sdi2, done2, busy2;
  logic [W2-1:0] din2, dout2, chain2;

  gf180mcu_fd_sc_mcu9t5v0__cfg_chain_ctrl #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
    .SDO(sdo), .SCE(sce), .SDI(sdi), .DOUT(dout), .DONE(done), .BUSY(busy)
  );

  gf180mcu_fd_sc_mcu9t5v0__cfg_chain_ctrl #(.WIDTH(W2)) dut2 (
    .CLK(clk), .RST(rst2), .DIN(din2), .DIN_VALID(valid2), .DIN_READY(ready2),
    .SDO(sdo2), .SCE(sce2), .SDI(sdi2), .DOUT(dout2), .DONE(done2), .BUSY(busy2)
  );

  // Behavioural chains: flop 0 is the head, the top flop is the tail.
  always @(posedge clk) if (sce) chain <= {chain[W-2:0], sdo};
  always @(posedge clk) if (sce2) chain2 <= {chain2[W2-2:0], sdo2};
  assign sdi  = chain[W-1];
  assign sdi2 = chain2[W2-1];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  exp_t         sb[$];
  logic [W-1:0] last_word   = '0;
  logic         last_known  = 1'b0;
  logic         active      = 1'b0;
  logic [W-1:0] cur_word    = '0;
  int           sce_cnt     = 0;
  int           cyc         = 0;
  int           accept_cyc  = 0;
  logic         hold_mode   = 1'b0;
  logic         prev_hold   = 1'b0;
  logic         w2_finished = 1'b0;

  // Monitor: the chain holds the last fully loaded word, so each DONE must return it.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    check_output("ready_busy_excl", W'(busy & din_ready), '0);
    if (active) begin
      if (sce) begin
        if (sce_cnt < W) check_output("sdo_bit", W'(sdo), W'(cur_word[sce_cnt]));
        sce_cnt++;
      end
      if (done) begin
        check_output("sce_cycles", W'(sce_cnt), W'(W));
        check_output("done_latency", W'(cyc - accept_cyc), W'(W + 1));
        if (sb.size() == 0) begin
          check_output("sb_underflow", W'(1), '0);
        end else begin
          e = sb.pop_front();
          if (e.known) check_output("dout", dout, e.word);
        end
        active = 1'b0;
      end
    end else begin
      check_output("sce_idle", W'(sce), '0);
      check_output("done_idle", W'(done), '0);
    end
    if (rst) begin
      if (active) begin
        void'(sb.pop_back());
        last_known = 1'b0;
      end
      active = 1'b0;
    end else if (din_valid && din_ready) begin
      check_output("accept_while_busy", W'(active), '0);
      if (hold_mode && prev_hold) check_output("b2b_interval", W'(cyc - accept_cyc), W'(W + 2));
      sb.push_back('{known: last_known, word: last_word});
      last_word  = din;
      last_known = 1'b1;
      cur_word   = din;
      active     = 1'b1;
      sce_cnt    = 0;
      accept_cyc = cyc;
      prev_hold  = hold_mode;
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("accept_timeout", W'(din_ready), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("done_timeout", W'(done), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [W-1:0] word);
    din       = word;
    din_valid = 1'b1;
    wait_accept();
    din_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_ready"}, W'(din_ready), W'(1));
    check_output({tag, "_sce"}, W'(sce), '0);
    check_output({tag, "_done"}, W'(done), '0);
    check_output({tag, "_busy"}, W'(busy), '0);
    check_output({tag, "_dout"}, dout, '0);
  endtask

  initial begin
    int n;
    rst = 1'b1; din = '0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_idle("reset");
      check_output("reset_sdo", W'(sdo), '0);
    end
    @(posedge clk);
    #1;

    apply_stimulus(16'hA5C3);
    wait_done();
    apply_stimulus(16'h1234);
    wait_done();

    // Valid held high across two words.
    hold_mode = 1'b1;
    din       = 16'h0F0F;
    din_valid = 1'b1;
    wait_accept();
    din = 16'hBEEF;
    wait_accept();
    din_valid = 1'b0;
    hold_mode = 1'b0;
    wait_done();

    // Reset during SHIFT cycle 7.
    apply_stimulus(16'h5A5A);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle("midrst");
    repeat (3) begin
      @(negedge clk);
      check_output("midrst_no_done", W'(done), '0);
    end
    @(posedge clk);
    #1;
    apply_stimulus(16'hFFFF);
    wait_done();
    apply_stimulus(16'h0000);
    wait_done();

    // Random words with DIN/DIN_VALID churn during the shift.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(W'($urandom));
      n = 0;
      while (!done && n < 40) begin
        din_valid = 1'($urandom_range(0, 1));
        din       = W'($urandom);
        @(posedge clk);
        #1;
        n++;
      end
      din_valid = 1'b0;
      check_output("rand_done_timeout", W'(done), W'(1));
      @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    check_output("sb_empty", W'(sb.size()), '0);
    n = 0;
    while (!w2_finished && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_output("w2_timeout", W'(w2_finished), W'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Minimum-width corner: second load returns the first word.
  initial begin
    int n, cnt;
    logic [W2-1:0] words[2];
    words[0] = 2'b10;
    words[1] = 2'b01;
    rst2 = 1'b1; din2 = '0; valid2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int t = 0; t < 2; t++) begin
      din2   = words[t];
      valid2 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ready2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_output("w2_accept_timeout", W'(ready2), W'(1));
      @(posedge clk);
      #1 valid2 = 1'b0;
      cnt = 0;
      n   = 0;
      @(negedge clk);
      while (!done2 && n < 20) begin
        if (sce2) cnt++;
        @(negedge clk);
        n++;
      end
      check_output("w2_sce_cycles", W'(cnt), W'(2));
      check_output("w2_done", W'(done2), W'(1));
      if (t == 1) check_output("w2_dout", W'(dout2), W'(2'b10));
      @(posedge clk);
      #1;
    end
    w2_finished = 1'b1;
  end

endmodule
